// File: rtl/rr_event_arbiter.sv
// Round-robin, burst-limited arbiter merging NMODULES word streams into one
// registered output stage toward the Ethernet TX FIFO.
module rr_event_arbiter #(
  parameter int NMODULES  = 4,
  parameter int LENGTH    = 128,
  parameter int MAX_BURST = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NMODULES-1:0]          enable,
  input  logic [NMODULES-1:0]          in_valid,
  input  logic [NMODULES*LENGTH-1:0]   in_data,
  output logic [NMODULES-1:0]          in_ready,
  output logic                         out_valid,
  output logic [LENGTH-1:0]            out_data,
  output logic [$clog2(NMODULES)-1:0]  out_src,
  input  logic                         out_ready,
  output logic                         busy
);

  localparam int SW = $clog2(NMODULES);
  localparam int CW = $clog2(MAX_BURST + 1);
  localparam logic [CW-1:0]       LAST_CNT = CW'(MAX_BURST - 1);
  localparam logic [NMODULES-1:0] ONE_HOT0 = NMODULES'(1);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  state_t            state_r;
  state_t            next_state_s;
  logic [SW-1:0]     ptr_r;
  logic [SW-1:0]     next_ptr_s;
  logic [SW-1:0]     grant_r;
  logic [SW-1:0]     next_grant_s;
  logic [CW-1:0]     burst_cnt_r;
  logic [CW-1:0]     next_burst_cnt_s;

  logic              load_s;
  logic              xfer_s;
  logic              exit_s;
  logic              found_s;
  logic [SW-1:0]     pick_s;
  logic [SW-1:0]     idx_s;
  logic              hit_s;
  logic [LENGTH-1:0] grant_data_s;

  assign load_s       = ~out_valid | out_ready;
  assign grant_data_s = in_data[int'(grant_r) * LENGTH +: LENGTH];
  assign xfer_s       = |(in_ready & in_valid);
  assign busy         = (state_r == BURST);

  // Leaving a burst: burst limit reached, or the granted source went empty/disabled.
  assign exit_s = (xfer_s && (burst_cnt_r == LAST_CNT)) ||
                  !in_valid[grant_r] || !enable[grant_r];

  // Rotating search; walk downwards so the candidate closest to ptr wins last.
  always_comb begin
    found_s = 1'b0;
    pick_s  = ptr_r;
    idx_s   = ptr_r;
    hit_s   = 1'b0;
    for (int k = NMODULES - 1; k >= 0; k--) begin
      idx_s   = ptr_r + SW'(k);
      hit_s   = in_valid[idx_s] & enable[idx_s];
      pick_s  = hit_s ? idx_s : pick_s;
      found_s = found_s | hit_s;
    end
  end

  // Read strobe to the granted FIFO; gated by enable so a clear takes effect at once.
  always_comb begin
    if ((state_r == BURST) && enable[grant_r] && load_s) begin
      in_ready = ONE_HOT0 << grant_r;
    end else begin
      in_ready = '0;
    end
  end

  // Arbitration FSM next-state logic.
  always_comb begin
    next_state_s     = state_r;
    next_ptr_s       = ptr_r;
    next_grant_s     = grant_r;
    next_burst_cnt_s = burst_cnt_r;
    case (state_r)
      IDLE: begin
        if (found_s) begin
          next_grant_s     = pick_s;
          next_burst_cnt_s = '0;
          next_state_s     = BURST;
        end else begin
          next_state_s     = IDLE;
        end
      end
      BURST: begin
        if (xfer_s) begin
          next_burst_cnt_s = burst_cnt_r + CW'(1);
        end else begin
          next_burst_cnt_s = burst_cnt_r;
        end
        if (exit_s) begin
          next_state_s = IDLE;
          next_ptr_s   = grant_r + SW'(1);
        end else begin
          next_state_s = BURST;
        end
      end
      default: begin
        next_state_s = IDLE;
      end
    endcase
  end

  // Arbitration FSM state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= IDLE;
      ptr_r       <= '0;
      grant_r     <= '0;
      burst_cnt_r <= '0;
    end else begin
      state_r     <= next_state_s;
      ptr_r       <= next_ptr_s;
      grant_r     <= next_grant_s;
      burst_cnt_r <= next_burst_cnt_s;
    end
  end

  // Output pipeline register; overwritten in place when a transfer coincides with out_ready.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_src   <= '0;
    end else if (xfer_s) begin
      out_valid <= 1'b1;
      out_data  <= grant_data_s;
      out_src   <= grant_r;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_rr_event_arbiter.sv
// Directed, table-driven bench for rr_event_arbiter with a small upstream FIFO
// model and a per-source sequence scoreboard on the output stream.
module tb_rr_event_arbiter;

  localparam int N  = 4;
  localparam int L  = 32;
  localparam int SW = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst;
  logic [N-1:0]    enable, in_valid, in_ready;
  logic [N*L-1:0]  in_data;
  logic            out_valid, out_ready, busy;
  logic [L-1:0]    out_data;
  logic [SW-1:0]   out_src;

  logic [N-1:0]    en1, v1, r1;
  logic [N*L-1:0]  d1;
  logic            ov1, ordy1, busy1;
  logic [L-1:0]    od1;
  logic [SW-1:0]   os1;

  rr_event_arbiter #(.NMODULES(N), .LENGTH(L), .MAX_BURST(8)) dut (
    .clk(clk), .rst(rst), .enable(enable), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .out_valid(out_valid), .out_data(out_data), .out_src(out_src),
    .out_ready(out_ready), .busy(busy));

  rr_event_arbiter #(.NMODULES(N), .LENGTH(L), .MAX_BURST(1)) dut1 (
    .clk(clk), .rst(rst), .enable(en1), .in_valid(v1), .in_data(d1),
    .in_ready(r1), .out_valid(ov1), .out_data(od1), .out_src(os1),
    .out_ready(ordy1), .busy(busy1));

  int avail[N];
  int seq[N];
  int exp_seq[N];
  int src_log[$];
  int n_checks = 0;
  int n_pass   = 0;
  logic [N-1:0] acc;

  typedef struct {
    int         pre;
    logic [3:0] en;
    logic [3:0] v;
    int         exp;
  } vec_t;
  vec_t vecs[9];

  function automatic logic [L-1:0] mk(input int m, input int s);
    return {4'hA, 4'(m), 8'h5C, 16'(s)};
  endfunction

  function automatic int idx_of(input logic [N-1:0] a);
    int r;
    r = 4;
    if ($countones(a) > 1) r = 5;
    else for (int i = 0; i < N; i++) if (a[i]) r = i;
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      in_valid[i] = (avail[i] > 0);
      in_data[i*L +: L] = mk(i, seq[i]);
    end
  endtask

  // One clock: sample strobes before the edge, update FIFO model and scoreboard after it.
  task automatic step();
    logic          ot;
    logic [L-1:0]  od;
    logic [SW-1:0] os;
    #2;
    acc = in_valid & in_ready;
    ot  = out_valid & out_ready;
    od  = out_data;
    os  = out_src;
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      if (acc[i]) begin
        seq[i]++;
        avail[i]--;
      end
    end
    if (ot) begin
      chk("sb_word", od, mk(int'(os), exp_seq[os]));
      exp_seq[os]++;
      src_log.push_back(int'(os));
    end
    drive();
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    out_ready = 1'b1;
    enable    = '1;
    for (int i = 0; i < N; i++) begin
      avail[i]   = 0;
      seq[i]     = 0;
      exp_seq[i] = 0;
    end
    src_log.delete();
    drive();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int got;
    int nsteps;
    int first_src;
    int taken;
    int n1;
    logic [N-1:0] a1;

    rst = 1'b1;
    en1 = '1; v1 = '0; ordy1 = 1'b1;
    d1 = {mk(3, 0), mk(2, 0), mk(1, 0), mk(0, 0)};
    acc = '0;

    // pre: source of a one-word burst run first to move ptr to pre+1 (-1: none)
    vecs[0] = '{pre: -1, en: 4'hF, v: 4'b0001, exp: 0};
    vecs[1] = '{pre: -1, en: 4'hF, v: 4'b1000, exp: 3};
    vecs[2] = '{pre: -1, en: 4'hF, v: 4'b1010, exp: 1};
    vecs[3] = '{pre: -1, en: 4'b0110, v: 4'b1101, exp: 2};
    vecs[4] = '{pre: 1,  en: 4'hF, v: 4'b0011, exp: 0};
    vecs[5] = '{pre: 2,  en: 4'hF, v: 4'b1111, exp: 3};
    vecs[6] = '{pre: 3,  en: 4'hF, v: 4'b1100, exp: 2};
    vecs[7] = '{pre: 0,  en: 4'hF, v: 4'b0001, exp: 0};
    vecs[8] = '{pre: -1, en: 4'h0, v: 4'b1111, exp: 4};

    // Reset: asynchronous clear of a loaded output register
    do_reset();
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    avail[0] = 4;
    drive();
    step();
    step();
    chk("pre_rst_valid", out_valid, 1'b1);
    chk("pre_rst_ready", in_ready, 4'b0001);
    #3;
    rst = 1'b1;
    #1;
    chk("rst_async_valid", out_valid, 1'b0);
    chk("rst_async_data", out_data, 32'h0);
    chk("rst_async_src", out_src, 2'd0);
    chk("rst_async_ready", in_ready, 4'b0000);
    chk("rst_async_busy", busy, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    avail[0] = 0;
    drive();
    step();
    step();
    chk("post_rst_busy", busy, 1'b0);
    chk("post_rst_ready", in_ready, 4'b0000);

    // Arbitration search vectors
    for (int t = 0; t < 9; t++) begin
      do_reset();
      if (vecs[t].pre >= 0) begin
        avail[vecs[t].pre] = 1;
        drive();
        repeat (3) step();
      end
      for (int i = 0; i < N; i++) avail[i] = vecs[t].v[i] ? 2 : 0;
      enable = vecs[t].en;
      drive();
      step();
      chk($sformatf("vec%0d_busy", t), busy, (vecs[t].exp != 4));
      step();
      if (vecs[t].exp == 4) begin
        chk($sformatf("vec%0d_valid", t), out_valid, 1'b0);
      end else begin
        chk($sformatf("vec%0d_valid", t), out_valid, 1'b1);
        chk($sformatf("vec%0d_src", t), out_src, vecs[t].exp);
        chk($sformatf("vec%0d_data", t), out_data,
            mk(vecs[t].exp, (vecs[t].exp == vecs[t].pre) ? 1 : 0));
      end
    end

    // Fairness: four busy sources, bursts of 8 separated by one idle cycle
    do_reset();
    for (int i = 0; i < N; i++) avail[i] = 100;
    drive();
    got = 0;
    for (int c = 0; c < 200 && got < 100; c++) begin
      step();
      chk($sformatf("fair_c%0d", c), idx_of(acc), (c % 9 == 0) ? 4 : ((c / 9) % 4));
      if (acc != '0) got++;
    end
    chk("fair_words", got, 100);

    // Single source: 36 words from module 2
    do_reset();
    avail[2] = 36;
    drive();
    got = 0;
    nsteps = 0;
    for (int c = 0; c < 100 && got < 36; c++) begin
      step();
      nsteps++;
      chk($sformatf("single_c%0d", c), idx_of(acc), (c % 9 == 0) ? 4 : 2);
      if (acc != '0) got++;
    end
    chk("single_cycles", nsteps, 41);
    step();
    avail[1] = 1;
    avail[3] = 1;
    drive();
    step();
    step();
    chk("single_ptr_next", idx_of(acc), 3);

    // Backpressure: stall with a word held in the output register
    do_reset();
    avail[0] = 20;
    drive();
    repeat (3) step();
    out_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      step();
      chk("bp_data", out_data, mk(0, 1));
      chk("bp_src", out_src, 2'd0);
      chk("bp_valid", out_valid, 1'b1);
      chk("bp_ready", in_ready, 4'b0000);
    end
    out_ready = 1'b1;
    for (int c = 0; c < 80 && (avail[0] != 0 || out_valid); c++) step();
    chk("bp_all_out", exp_seq[0], 20);
    chk("bp_all_read", avail[0], 0);

    // Enable drop after three words of module 1
    do_reset();
    avail[1] = 10;
    avail[2] = 10;
    drive();
    for (int c = 0; c < 20 && seq[1] < 3; c++) step();
    chk("drop_reached", seq[1], 3);
    chk("drop_ready_before", in_ready, 4'b0010);
    enable[1] = 1'b0;
    #1;
    chk("drop_ready_same_cycle", in_ready, 4'b0000);
    first_src = 4;
    taken = 0;
    for (int c = 0; c < 40 && taken < 10; c++) begin
      step();
      if (acc != '0) begin
        if (taken == 0) first_src = idx_of(acc);
        taken++;
      end
    end
    chk("drop_next_burst", first_src, 2);
    chk("drop_m1_reads", seq[1], 3);
    n1 = 0;
    foreach (src_log[k]) if (src_log[k] == 1) n1++;
    chk("drop_m1_out", n1, 3);

    // MAX_BURST=1 instance: modules 0 and 3 alternate with an idle cycle between
    do_reset();
    v1 = 4'b1001;
    for (int c = 0; c < 8; c++) begin
      #2;
      a1 = v1 & r1;
      @(posedge clk);
      #1;
      chk($sformatf("mb1_c%0d", c), idx_of(a1),
          (c % 2 == 0) ? 4 : (((c / 2) % 2 == 0) ? 0 : 3));
      if (a1 != '0) chk($sformatf("mb1_src_c%0d", c), os1, idx_of(a1));
    end
    v1 = '0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/rr_event_arbiter.md
Name: rr_event_arbiter

Overview:
- Round-robin, burst-limited arbiter that merges the per-module singles/timetag FIFO outputs (NMODULES requesters, LENGTH-bit words) into one stream toward the Ethernet TX FIFO.
- Replaces fixed priority so no module can starve another. Per-module enable mask comes from the microblaze GPIO.
- Output is a registered pipeline stage, which breaks the wide mux path to the Ethernet FIFO.

Parameters:
- NMODULES, 4: number of requesters. Must be a power of 2, ≥2.
- LENGTH, 128: word width in bits.
- MAX_BURST, 8: maximum consecutive words granted to one requester before rotating. Range ≥1.

Ports:
- clk  input  1  system clock (sys_clk domain)
- rst  input  1  asynchronous, active-high reset
- enable  input  NMODULES  per-module arbitration enable (GPIO)
- in_valid  input  NMODULES  per-module word available (FIFO not empty)
- in_data  input  NMODULES*LENGTH  module i word on in_data[i*LENGTH +: LENGTH]
- in_ready  output  NMODULES  per-module read strobe; at most one bit set
- out_valid  output  1  registered word valid
- out_data  output  LENGTH  registered word
- out_src  output  $clog2(NMODULES)  source module of out_data
- out_ready  input  1  downstream accepts (Ethernet FIFO not full)
- busy  output  1  state == BURST

Behaviour:
- Reset (async, immediate):
  - out_valid=0, out_data=0, out_src=0.
  - state=IDLE, ptr=0, grant=0, burst_cnt=0.
  - in_ready=0 combinationally while state is IDLE.
- Transfers:
  - Input transfer: in_valid[i] & in_ready[i] at a rising edge.
  - Output transfer: out_valid & out_ready.
- load = ~out_valid | out_ready. The output register accepts a new word only when load=1.
- in_ready[i] = (state==BURST) & (grant==i) & enable[i] & load. This is combinational and one-hot or zero.
- Output register update on each edge:
  - Input transfer: out_data ← in_data[grant], out_src ← grant, out_valid ← 1.
  - Else, if out_ready: out_valid ← 0. out_data and out_src hold.
  - Latency: a word accepted at edge N is visible on out_* after edge N and stays stable until its output transfer.
- State IDLE (one arbitration cycle):
  - Search starts at ptr and ascends modulo NMODULES for the first i with in_valid[i] & enable[i].
  - If found: grant ← i, burst_cnt ← 0, state ← BURST.
  - If none: stay IDLE, ptr unchanged.
- State BURST:
  - On each input transfer: burst_cnt ← burst_cnt+1.
  - Exit to IDLE at the edge where any of the following holds:
    - (a) an input transfer occurs with burst_cnt == MAX_BURST-1;
    - (b) in_valid[grant]==0;
    - (c) enable[grant]==0.
  - On exit: ptr ← (grant+1) mod NMODULES.
  - out_ready low does not cause an exit. The grant is held, stalled, until load returns.
- Widths: burst_cnt is $clog2(MAX_BURST+1) bits; ptr and grant are $clog2(NMODULES) bits. Wrap is natural modulo.
- Boundary cases:
  - MAX_BURST=1: every transfer rotates, giving 1 word then 1 IDLE cycle.
  - Single active requester: bursts of MAX_BURST separated by one IDLE cycle; throughput MAX_BURST/(MAX_BURST+1).
  - enable cleared mid-burst: in_ready for that module drops in the same cycle. No word is transferred after the clear.
  - enable set while in_valid is already high: eligible from the next IDLE search.
  - Simultaneous out_ready and input transfer: the register is overwritten in place with no bubble.
  - Reset mid-burst: any word in the output register is discarded. Upstream FIFO words not yet strobed are not lost.
- No data path modification; the word is passed bit-exact.

Test Plan:
1. Reset:
   - Stimulus: load a word so out_valid=1, then assert rst between edges.
   - Required: out_valid, out_data and in_ready go to 0 without a clock edge. After release with no requests, busy=0 and in_ready=0.
2. Fairness:
   - Stimulus: all 4 in_valid=1, enable=4'hF, out_ready=1, MAX_BURST=8, 100 words.
   - Required: out_src sequence is 0×8, 1×8, 2×8, 3×8, repeating, with exactly one idle cycle (no in_ready) between bursts.
3. Single source:
   - Stimulus: only module 2 valid (enable=4'hF), 36 words.
   - Required: 4 bursts of 8 plus 4 words, with ptr=3 after each burst. Total cycles = 36+5.
4. Backpressure:
   - Stimulus: out_ready=0 for 5 cycles while out_valid=1.
   - Required: out_data and out_src are stable and in_ready=0. On out_ready=1 the words resume in order, with no duplicate and no loss (scoreboard sequence numbers).
5. Enable drop:
   - Stimulus: clear enable[1] after 3 of module 1's words.
   - Required: in_ready[1]=0 in the same cycle, exactly 3 words carry out_src=1, and the next burst is module 2.
6. MAX_BURST=1 build:
   - Stimulus: modules 0 and 3 valid.
   - Required: out_src alternates 0,3,0,3 with one idle cycle between words.
